countdown_timer: RTL

- Loadable down-counter timer: the decrementing counterpart of the free-running up counter, for trigger and timeout generation in the test designs.
- Accepts a load value through a valid/ready handshake and counts down to zero once started.
- Emits a one-cycle expiry pulse at zero; optionally auto-reloads; keeps a saturating count of expirations.
- Gives the analysis flow a counter with load, hold, wrap and terminal-event behaviour to exercise.

---
 rtl/countdown_timer.sv | 105 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause/stop control, expiry pulse,
// optional auto-reload and a saturating expiration counter.
module countdown_timer #(
  parameter int WIDTH = 4,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic [EXP_W-1:0] exp_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_PAUSED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q, auto_d;
  logic             expired_q, expired_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             hs;

  assign load_ready = (state_q == S_IDLE) || (state_q == S_ARMED);
  assign hs         = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    auto_d    = auto_q;
    expired_d = 1'b0;
    exp_d     = exp_q;
    if (hs) begin
      count_d  = load_value;
      reload_d = load_value;
      auto_d   = auto_reload;
    end
    unique case (state_q)
      S_IDLE: begin
        if (hs) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (hs)         state_d = S_ARMED;
        else if (stop)  state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // terminal count: pulse, tally, then reload or retire
          expired_d = 1'b1;
          if (exp_q != '1) exp_d = exp_q + EXP_W'(1);
          if (auto_q) count_d = reload_q;
          else        state_d = S_IDLE;
        end
      end
      S_PAUSED: begin
        if (stop)        state_d = S_IDLE;
        else if (!pause) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
      exp_q     <= exp_d;
    end
  end

  assign count     = count_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign expired   = expired_q;
  assign exp_count = exp_q;

endmodule
